sum_accum: RTL and testbench

- Sequential stage directly downstream of the 2-bit combinational adder; consumes its sum output.
- Accepts a stream of adder sums over a valid/ready handshake and accumulates COUNT samples into a wider register.
- Presents the batch total with an overflow flag on an output handshake, then clears and starts the next batch.
- Exercises synthesis of FSM, counter and accumulator logic around the adder.

---
 rtl/sum_accum.sv | 93 +++++++++
 tb/tb_sum_accum.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accum.sv
// Batch accumulator behind the 2-bit adder: sums COUNT accepted samples, then holds the
// total and an overflow flag on an output handshake. Define SUM_ACCUM_SAT_EN to saturate instead of wrap.
module sum_accum #(
  parameter int IN_W  = 2,
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf;

  logic             accept;
  logic             last;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic             ovf_nxt;
  logic [ACC_W-1:0] acc_nxt;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST_CNT);

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
    carry   = sum_ext[ACC_W];
    ovf_nxt = ovf | carry;
`ifdef SUM_ACCUM_SAT_EN
    // Once the batch has overflowed the accumulator pins at all-ones.
    acc_nxt = ovf_nxt ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_nxt = sum_ext[ACC_W-1:0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= ACCUM;
        ACCUM: begin
          if (accept) begin
            acc <= acc_nxt;
            ovf <= ovf_nxt;
            cnt <= cnt + 8'd1;
            if (last) begin
              out_sum <= acc_nxt;
              out_ovf <= ovf_nxt;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          // Results stay on out_sum/out_ovf after the handshake; only the batch state clears.
          if (out_ready) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= ACCUM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accum.sv
// Random and directed bench for sum_accum; two instances (ACC_W=8 and ACC_W=3) share stimulus
// and are checked against a batch-level reference model.
module tb_sum_accum;

  localparam int COUNT = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_data = 2'd0;
  logic       out_ready = 1'b0;

  logic       in_ready8, out_valid8, out_ovf8;
  logic [7:0] out_sum8;
  logic       in_ready3, out_valid3, out_ovf3;
  logic [2:0] out_sum3;

  sum_accum #(.IN_W(2), .ACC_W(8), .COUNT(COUNT)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .out_valid(out_valid8), .out_ready(out_ready),
    .out_sum(out_sum8), .out_ovf(out_ovf8)
  );

  sum_accum #(.IN_W(2), .ACC_W(3), .COUNT(COUNT)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready),
    .out_sum(out_sum3), .out_ovf(out_ovf3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: batch samples in a queue, result derived from their plain integer total.
  int  batch[$];
  bit  started;
  bit  exp_valid;
  bit  exp_ready;
  int  exp_sum8, exp_sum3;
  bit  exp_ovf8, exp_ovf3;
  bit  last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int result_of(input int total, input int w);
    int max_v = (1 << w) - 1;
    if (total <= max_v) return total;
`ifdef SUM_ACCUM_SAT_EN
    return max_v;
`else
    return total % (max_v + 1);
`endif
  endfunction

  task automatic compare_all();
    check("in_ready8",  32'(in_ready8),  32'(exp_ready));
    check("in_ready3",  32'(in_ready3),  32'(exp_ready));
    check("out_valid8", 32'(out_valid8), 32'(exp_valid));
    check("out_valid3", 32'(out_valid3), 32'(exp_valid));
    check("out_sum8",   32'(out_sum8),   32'(exp_sum8));
    check("out_ovf8",   32'(out_ovf8),   32'(exp_ovf8));
    check("out_sum3",   32'(out_sum3),   32'(exp_sum3));
    check("out_ovf3",   32'(out_ovf3),   32'(exp_ovf3));
  endtask

  task automatic model_reset();
    batch.delete();
    started   = 1'b0;
    exp_valid = 1'b0;
    exp_ready = 1'b0;
    exp_sum8  = 0;
    exp_sum3  = 0;
    exp_ovf8  = 1'b0;
    exp_ovf3  = 1'b0;
  endtask

  // One clock: note the handshakes about to happen, advance the clock, update the model, compare.
  task automatic tick();
    bit acc_ok, out_ok;
    int total;
    acc_ok = in_valid && exp_ready;
    out_ok = exp_valid && out_ready;
    @(posedge clk);
    #1;
    last_acc = acc_ok;
    if (!started) begin
      started = 1'b1;
    end else if (exp_valid) begin
      if (out_ok) exp_valid = 1'b0;
    end else if (acc_ok) begin
      batch.push_back(int'(in_data));
      if (batch.size() == COUNT) begin
        total = 0;
        foreach (batch[i]) total += batch[i];
        exp_sum8  = result_of(total, 8);
        exp_ovf8  = (total > 255);
        exp_sum3  = result_of(total, 3);
        exp_ovf3  = (total > 7);
        exp_valid = 1'b1;
        batch.delete();
      end
    end
    exp_ready = started && !exp_valid;
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid8", 32'(out_valid8), 32'd0);
    check("rst_out_valid3", 32'(out_valid3), 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    reset_n = 1'b1;
    compare_all();
  endtask

  task automatic send(input logic [1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_batch(input int a, input int b, input int c, input int d);
    send(2'(a));
    send(2'(b));
    send(2'(c));
    send(2'(d));
  endtask

  initial begin
    logic [1:0] add_a, add_b;
    int sat_sum3;

    model_reset();

    // Reset then idle
    do_reset(2);
    in_valid = 1'b0;
    repeat (5) tick();
    check("idle_in_ready", 32'(in_ready8), 32'd1);
    check("idle_out_sum",  32'(out_sum8),  32'd0);

    // Basic batch with continuous valid; result visible the cycle after the 4th accept
    out_ready = 1'b1;
    send_batch(2, 2, 2, 2);
    check("basic_valid", 32'(out_valid8), 32'd1);
    check("basic_sum",   32'(out_sum8),   32'd8);
    check("basic_ovf",   32'(out_ovf8),   32'd0);
    tick();
    check("basic_cleared", 32'(out_valid8), 32'd0);
    check("basic_sum_kept", 32'(out_sum8), 32'd8);

    // Backpressure: result held, no inputs consumed, exit cycle refuses input
    do_reset(2);
    tick();
    out_ready = 1'b0;
    send_batch(1, 0, 1, 1);
    in_valid = 1'b1;
    in_data  = 2'd2;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_sum",      32'(out_sum8), 32'd3);
      check("bp_no_accept", 32'(last_acc), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_exit_no_accept", 32'(last_acc), 32'd0);
    tick();
    check("bp_next_accept", 32'(last_acc), 32'd1);
    in_valid = 1'b0;

    // Overflow on the 3-bit instance, then a clean batch
    do_reset(2);
    tick();
`ifdef SUM_ACCUM_SAT_EN
    sat_sum3 = 7;
`else
    sat_sum3 = 1;
`endif
    send_batch(3, 3, 3, 0);
    check("ovf_sum3", 32'(out_sum3), 32'(sat_sum3));
    check("ovf_ovf3", 32'(out_ovf3), 32'd1);
    check("ovf_sum8", 32'(out_sum8), 32'd9);
    check("ovf_ovf8", 32'(out_ovf8), 32'd0);
    send_batch(1, 1, 1, 1);
    check("post_ovf_sum3", 32'(out_sum3), 32'd4);
    check("post_ovf_ovf3", 32'(out_ovf3), 32'd0);

    // Reset mid-batch discards the partial sum
    do_reset(2);
    tick();
    send(2'd3);
    send(2'd3);
    do_reset(1);
    send_batch(1, 1, 1, 1);
    check("midrst_sum", 32'(out_sum8), 32'd4);
    check("midrst_ovf", 32'(out_ovf8), 32'd0);

    // End to end through the adder: a = b = d
    do_reset(2);
    tick();
    for (int d = 1; d >= 0; d--) begin
      add_a = 2'(d);
      add_b = 2'(d);
      for (int k = 0; k < COUNT; k++) send(add_a + add_b);
      check("e2e_sum", 32'(out_sum8), 32'(8 * d));
    end

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = 2'($urandom);
        out_ready = $urandom_range(0, 1) == 1;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
